// File: rtl/game_pkg.sv
// Shared bulls-and-cows types: digit/entry containers, entry FSM states, game state codes,
// plus the digit-validation helpers used by the input front end.
package game_pkg;

    typedef logic [3:0] digit_t;
    typedef digit_t [3:0] entry_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        VALID,
        WAIT_REL
    } entry_state_t;

    localparam logic [2:0] GAME_SETUP = 3'd0;
    localparam logic [2:0] GAME_GUESS = 3'd1;
    localparam logic [2:0] GAME_SCORE = 3'd2;
    localparam logic [2:0] GAME_WON   = 3'd3;

    function automatic logic digits_in_range(input entry_t e, input digit_t max_digit);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (e[i] > max_digit) ok = 1'b0;
        end
        return ok;
    endfunction

    // True when no two of the four digits are equal (six pairwise compares).
    function automatic logic digits_distinct(input entry_t e);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (e[i] == e[j]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/game_input_entry_if.sv
// Entry handshake between the player-input front end (master) and the game FSM (slave).
interface game_input_entry_if;
    logic        entry_enable;
    logic        entry_ack;
    logic [15:0] entry_data;
    logic        entry_valid;
    logic        entry_error;
    logic        entry_busy;

    modport master (
        input  entry_enable,
        input  entry_ack,
        output entry_data,
        output entry_valid,
        output entry_error,
        output entry_busy
    );

    modport slave (
        output entry_enable,
        output entry_ack,
        input  entry_data,
        input  entry_valid,
        input  entry_error,
        input  entry_busy
    );
endinterface

// File: rtl/input_debouncer.sv
// Two-FF synchronizer followed by a stability counter; btn_stable follows the button only
// after it has held a new level for DEBOUNCE_COUNT consecutive cycles.
module input_debouncer #(
    parameter int DEBOUNCE_COUNT = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic btn_stable
);
    localparam int CW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            if (sync2_reg != stable_reg) begin
                if (count_reg == CW'(DEBOUNCE_COUNT - 1)) begin
                    stable_reg <= sync2_reg;
                    count_reg  <= '0;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign btn_stable = stable_reg;

endmodule

// File: rtl/game_input_entry.sv
// Player-input front end: debounced confirm button captures SW as four digits, validates them
// and offers them over a valid/ack handshake. Define GAME_INPUT_DISTINCT_CHECK_EN to reject repeated digits.
module game_input_entry
    import game_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 1_000_000,
    parameter int DIGIT_MAX      = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          SW,
    input  logic                 BTN_CONFIRM,
    game_input_entry_if.master   entry
);
    logic         btn_stable;
    logic         btn_stable_d_reg;
    logic         press;
    entry_state_t state_reg;
    entry_state_t state_next;
    entry_t       entry_data_reg;
    logic         error_reg;
    logic         error_next;
    logic         capture;
    logic         entry_ok;

    input_debouncer #(
        .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_confirm_debouncer (
        .clock      (clock),
        .reset      (reset),
        .btn        (BTN_CONFIRM),
        .btn_stable (btn_stable)
    );

    assign press = btn_stable & ~btn_stable_d_reg;

`ifdef GAME_INPUT_DISTINCT_CHECK_EN
    assign entry_ok = digits_in_range(entry_data_reg, digit_t'(DIGIT_MAX))
                    & digits_distinct(entry_data_reg);
`else
    assign entry_ok = digits_in_range(entry_data_reg, digit_t'(DIGIT_MAX));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            btn_stable_d_reg <= 1'b0;
            entry_data_reg   <= '0;
            error_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            btn_stable_d_reg <= btn_stable;
            error_reg        <= error_next;
            if (capture) entry_data_reg <= entry_t'(SW);
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        error_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (press && entry.entry_enable) begin
                    state_next = CHECK;
                    capture    = 1'b1;
                end else if (press) begin
                    state_next = WAIT_REL;
                end
            end
            CHECK: begin
                if (entry_ok) begin
                    state_next = VALID;
                end else begin
                    state_next = WAIT_REL;
                    error_next = 1'b1;
                end
            end
            VALID: begin
                // An ack in the same cycle as a withdrawal still counts as accepted.
                if (entry.entry_ack || !entry.entry_enable) state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (!btn_stable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign entry.entry_data  = entry_data_reg;
    assign entry.entry_valid = (state_reg == VALID);
    assign entry.entry_error = error_reg;
    assign entry.entry_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_game_input_entry.sv
// Scoreboard bench for game_input_entry: stimulus queues expected offers/errors, a monitor checks them.
module tb_game_input_entry;
    logic        clock;
    logic        reset;
    logic [15:0] sw;
    logic        btn;

    game_input_entry_if ent_if ();

    game_input_entry #(
        .DEBOUNCE_COUNT(4),
        .DIGIT_MAX(9)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .SW          (sw),
        .BTN_CONFIRM (btn),
        .entry       (ent_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   valid_prev = 0;
    bit   err_prev   = 0;

    // Monitor: every rising entry_valid and every entry_error cycle must match the queue head.
    always @(negedge clock) begin
        if (reset) begin
            valid_prev = 0;
            err_prev   = 0;
        end else begin
            if (ent_if.entry_valid === 1'b1 && !valid_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid data=%h required=no_entry", ent_if.entry_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_err || ent_if.entry_data !== e.data) begin
                        failures++;
                        $display("FAIL offer got valid data=%h required is_err=%0d data=%h",
                                 ent_if.entry_data, e.is_err, e.data);
                    end else
                        $display("offer ok data=%h", ent_if.entry_data);
                end
            end
            if (ent_if.entry_error === 1'b1) begin
                checks++;
                if (err_prev) begin
                    failures++;
                    $display("FAIL error_width got=2+ cycles required=1");
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_error data=%h required=no_error", ent_if.entry_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (!e.is_err || ent_if.entry_data !== e.data) begin
                        failures++;
                        $display("FAIL reject got error data=%h required is_err=%0d data=%h",
                                 ent_if.entry_data, e.is_err, e.data);
                    end else
                        $display("reject ok data=%h", ent_if.entry_data);
                end
            end
            valid_prev = (ent_if.entry_valid === 1'b1);
            err_prev   = (ent_if.entry_error === 1'b1);
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else
            $display("check %s ok value=%h", name, got);
    endtask

    function automatic bit cond(input int sel);
        if (sel == 0) return ent_if.entry_valid === 1'b1;
        return ent_if.entry_busy === 1'b0;
    endfunction

    // Bounded wait, ending on a negedge; a timeout counts as a failed comparison.
    task automatic wait_until(input int sel, input string name);
        int n = 0;
        @(negedge clock);
        while (!cond(sel) && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!cond(sel)) begin
            failures++;
            $display("FAIL %s timeout got=not_reached required=reached", name);
        end else
            $display("wait %s ok after %0d cycles", name, n);
    endtask

    task automatic expect_entry(input bit is_err, input logic [15:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic release_btn(input string name);
        btn = 1'b0;
        wait_until(1, name);
    endtask

    task automatic ack_and_check(input string name);
        ent_if.entry_ack = 1'b1;
        @(posedge clock); #1;
        ent_if.entry_ack = 1'b0;
        check(name, {15'b0, ent_if.entry_valid}, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        sw = 16'h0;
        btn = 1'b0;
        ent_if.entry_enable = 1'b0;
        ent_if.entry_ack = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", {15'b0, ent_if.entry_valid}, 16'h0);
        check("rst_error", {15'b0, ent_if.entry_error}, 16'h0);
        check("rst_busy",  {15'b0, ent_if.entry_busy},  16'h0);
        check("rst_data",  ent_if.entry_data, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1: valid entry, data held against SW changes, ack drops valid next cycle
        ent_if.entry_enable = 1'b1;
        sw = 16'h1234;
        expect_entry(0, 16'h1234);
        btn = 1'b1;
        wait_until(0, "t1_valid");
        sw = 16'hFFFF;
        repeat (2) @(negedge clock);
        check("t1_data_held", ent_if.entry_data, 16'h1234);
        check("t1_still_valid", {15'b0, ent_if.entry_valid}, 16'h1);
        ack_and_check("t1_ack_drop");
        release_btn("t1_idle");

        // 2: bouncing button, then held: exactly one entry
        sw = 16'h5678;
        expect_entry(0, 16'h5678);
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            repeat (2) @(negedge clock);
        end
        btn = 1'b1;
        wait_until(0, "t2_valid");
        ack_and_check("t2_ack_drop");
        repeat (10) @(negedge clock);
        release_btn("t2_idle");

        // 3: out-of-range digit
        sw = 16'h12A4;
        expect_entry(1, 16'h12A4);
        btn = 1'b1;
        repeat (20) @(negedge clock);
        check("t3_busy_held", {15'b0, ent_if.entry_busy}, 16'h1);
        release_btn("t3_idle");

        // 4: repeated digits
        sw = 16'h1123;
`ifdef GAME_INPUT_DISTINCT_CHECK_EN
        expect_entry(1, 16'h1123);
        btn = 1'b1;
        repeat (20) @(negedge clock);
`else
        expect_entry(0, 16'h1123);
        btn = 1'b1;
        wait_until(0, "t4_valid");
        ack_and_check("t4_ack_drop");
`endif
        release_btn("t4_idle");

        // 5: withdrawal, then a fresh press offers new data
        sw = 16'h4321;
        expect_entry(0, 16'h4321);
        btn = 1'b1;
        wait_until(0, "t5_valid");
        ent_if.entry_enable = 1'b0;
        @(posedge clock); #1;
        check("t5_withdraw", {15'b0, ent_if.entry_valid}, 16'h0);
        release_btn("t5_idle");
        ent_if.entry_enable = 1'b1;
        sw = 16'h8765;
        expect_entry(0, 16'h8765);
        btn = 1'b1;
        wait_until(0, "t5_new_valid");
        ack_and_check("t5_ack_drop");
        release_btn("t5_idle2");

        // Press while the game FSM is not accepting: no entry, busy until release
        ent_if.entry_enable = 1'b0;
        sw = 16'h1357;
        btn = 1'b1;
        repeat (20) @(negedge clock);
        check("t7_busy_no_enable", {15'b0, ent_if.entry_busy}, 16'h1);
        release_btn("t7_idle");
        ent_if.entry_enable = 1'b1;

        // 6: asynchronous reset while VALID
        sw = 16'h0909;
        expect_entry(0, 16'h0909);
        btn = 1'b1;
        wait_until(0, "t6_valid");
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", {15'b0, ent_if.entry_valid}, 16'h0);
        check("t6_rst_busy",  {15'b0, ent_if.entry_busy},  16'h0);
        check("t6_rst_data",  ent_if.entry_data, 16'h0);
        btn = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("t6_no_entry", {15'b0, ent_if.entry_busy}, 16'h0);
        sw = 16'h2468;
        expect_entry(0, 16'h2468);
        btn = 1'b1;
        wait_until(0, "t6_new_valid");
        ack_and_check("t6_ack_drop");
        release_btn("t6_idle");

        repeat (5) @(negedge clock);
        check("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
